// File: rtl/mult_accum.sv
// rtl/mult_accum.sv - accumulates LEN unsigned products into one handshaked result
// Build macro MULT_ACCUM_SAT_EN selects saturating (defined) or wrapping (undefined) accumulation.
module mult_accum #(
  parameter int N     = 4,
  parameter int LEN   = 4,
  parameter int ACC_W = 2*N+2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   P,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int SUM_W = ((ACC_W > 2*N) ? ACC_W : 2*N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN-1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_p_ready;
  logic               r_acc_valid;
  logic               r_busy;
  logic               r_ovf;

  logic [SUM_W-1:0]   w_sum;
  logic               w_ovf;
  logic [ACC_W-1:0]   w_acc_next;

  // Sum is one bit wider than either operand so the true sum is never lost.
  assign w_sum = SUM_W'(r_acc) + SUM_W'(P);
  assign w_ovf = w_sum > SUM_W'({ACC_W{1'b1}});

`ifdef MULT_ACCUM_SAT_EN
  assign w_acc_next = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_p_ready   <= 1'b0;
      r_acc_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ACCUM;
            r_acc     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_p_ready <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (p_valid) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CNT_W'(1);
            if (w_ovf) r_ovf <= 1'b1;
            if (r_count == LAST) begin
              r_state     <= S_HOLD;
              r_p_ready   <= 1'b0;
              r_acc_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // start alongside acc_ready chains straight into the next accumulation.
          if (acc_ready) begin
            r_acc_valid <= 1'b0;
            if (start) begin
              r_state   <= S_ACCUM;
              r_acc     <= '0;
              r_count   <= '0;
              r_ovf     <= 1'b0;
              r_p_ready <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_p_ready   <= 1'b0;
          r_acc_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign p_ready   = r_p_ready;
  assign acc       = r_acc;
  assign acc_valid = r_acc_valid;
  assign busy      = r_busy;
  assign ovf       = r_ovf;

endmodule
